// File: rtl/cabac_refill_ctrl_if.sv
// Byte-source and decode-step bus between the CABAC decoder core and its refill controller.
// The decoder/source side is the master; the refill controller is the slave.
interface cabac_refill_ctrl_if #(
  parameter int BIN_WIDTH = 4
);
  localparam int NB_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

  logic            src_valid;
  logic [7:0]      src_data;
  logic            src_ready;

  logic            op_valid;
  logic            op_ready;
  logic            bypass;
  logic [NB_W-1:0] n_bin;
  logic            renorm;
  logic [2:0]      num_bits;

  logic            inject_en;
  logic [7:0]      inject_byte;
  logic [2:0]      inject_shift;
  logic [2:0]      inject_lane;

  modport master (
    output src_valid, src_data, op_valid, bypass, n_bin, renorm, num_bits,
    input  src_ready, op_ready, inject_en, inject_byte, inject_shift, inject_lane
  );

  modport slave (
    input  src_valid, src_data, op_valid, bypass, n_bin, renorm, num_bits,
    output src_ready, op_ready, inject_en, inject_byte, inject_shift, inject_lane
  );
endinterface

// File: rtl/cabac_refill_ctrl.sv
// CABAC bitstream refill controller: tracks the signed bits-needed counter, prefetches
// bitstream bytes into a small FIFO and tells the decoder when and where to inject them.
module cabac_refill_ctrl #(
  parameter int BIN_WIDTH  = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int INIT_BYTES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              init_valid,
  output logic [7:0]        init_data,
  output logic signed [3:0] bits_needed,
  output logic              busy,
  output logic              err,
  cabac_refill_ctrl_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, INIT, RUN} state_t;

  state_t            state_q, state_d;
  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        init_cnt_q, init_cnt_d;
  logic [3:0]        bn_q, bn_d;
  logic              err_q, err_d;

  logic              full, empty, run, need, op_bad, accept, push, pop;
  logic [7:0]        head;
  logic [3:0]        step;
  logic [4:0]        sum;

  always_comb begin
    full   = (cnt_q == CNT_W'(FIFO_DEPTH));
    empty  = (cnt_q == '0);
    head   = mem_q[rd_ptr_q];
    run    = (state_q == RUN) && !start;

    if (bus.bypass)      step = 4'(bus.n_bin) + 4'd1;
    else if (bus.renorm) step = {1'b0, bus.num_bits};
    else                 step = 4'd0;

    // Counter lives in -8..-1 and step is at most 8, so a 5-bit sum never overflows.
    sum  = {bn_q[3], bn_q} + {1'b0, step};
    need = !sum[4];

    op_bad = bus.op_valid &&
             ((state_q == IDLE) ||
              ((state_q == RUN) && (bus.bypass ? (int'(bus.n_bin) >= BIN_WIDTH)
                                               : (bus.num_bits > 3'd6))));

    bus.op_ready     = run && !op_bad && !(need && empty);
    accept           = bus.op_valid && bus.op_ready;
    bus.inject_en    = accept && need;
    bus.inject_byte  = bus.inject_en ? head : 8'd0;
    bus.inject_shift = (bus.inject_en && !bus.bypass) ? sum[2:0] : 3'd0;
    bus.inject_lane  = (bus.inject_en && bus.bypass) ? ~bn_q[2:0] : 3'd0;

    init_valid    = (state_q == INIT) && !start && !empty;
    init_data     = init_valid ? head : 8'd0;
    bus.src_ready = (state_q != IDLE) && !full;

    pop  = bus.inject_en || init_valid;
    push = bus.src_valid && bus.src_ready;

    state_d    = state_q;
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;
    init_cnt_d = init_cnt_q;
    bn_d       = bn_q;
    err_d      = err_q | op_bad;

    if (start) begin
      state_d    = INIT;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      cnt_d      = '0;
      init_cnt_d = '0;
      bn_d       = 4'b1000;
      err_d      = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = bus.src_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

      if (accept) bn_d = need ? {1'b1, sum[2:0]} : sum[3:0];

      if (init_valid) begin
        init_cnt_d = init_cnt_q + 3'd1;
        if (int'(init_cnt_q) + 1 == INIT_BYTES) state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'd0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
      init_cnt_q <= '0;
      bn_q       <= 4'b1000;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
      init_cnt_q <= init_cnt_d;
      bn_q       <= bn_d;
      err_q      <= err_d;
    end
  end

  assign bits_needed = $signed(bn_q);
  assign busy        = (state_q != RUN);
  assign err         = err_q;
endmodule

// File: tb/tb_cabac_refill_ctrl.sv
// Self-checking bench for cabac_refill_ctrl: directed init/stall/full/start/error sequences,
// a vector table for the counter arithmetic, and a randomized run against a queue-based model.
module tb_cabac_refill_ctrl;
  logic clk = 1'b0;
  logic reset, start, start3;
  always #5 clk = ~clk;

  cabac_refill_ctrl_if #(.BIN_WIDTH(4)) bus ();
  cabac_refill_ctrl_if #(.BIN_WIDTH(3)) bus3 ();

  logic              init_valid, busy, err, init_valid3, busy3, err3;
  logic [7:0]        init_data, init_data3;
  logic signed [3:0] bits_needed, bits_needed3;

  cabac_refill_ctrl #(.BIN_WIDTH(4), .FIFO_DEPTH(4), .INIT_BYTES(2)) dut (
    .clk(clk), .reset(reset), .start(start), .init_valid(init_valid), .init_data(init_data),
    .bits_needed(bits_needed), .busy(busy), .err(err), .bus(bus)
  );

  cabac_refill_ctrl #(.BIN_WIDTH(3), .FIFO_DEPTH(4), .INIT_BYTES(2)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .init_valid(init_valid3), .init_data(init_data3),
    .bits_needed(bits_needed3), .busy(busy3), .err(err3), .bus(bus3)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    bit ov; bit byp; int nb; bit ren; int nbits;
    bit sv; int sd;
    bit e_rdy; bit e_inj; int e_byte; int e_shift; int e_lane; int e_bn;
  } vec_t;
  vec_t vecs[12];

  logic [7:0] m_q[$];
  int m_bn;

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input bit ov, input bit byp, input int nb, input bit ren, input int nbits);
    bus.op_valid = ov;
    bus.bypass   = byp;
    bus.n_bin    = 2'(nb);
    bus.renorm   = ren;
    bus.num_bits = 3'(nbits);
  endtask

  task automatic drive_src(input bit v, input int d);
    bus.src_valid = v;
    bus.src_data  = 8'(d);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    #1;
    tick();
    start = 1'b0;
  endtask

  // Expects state INIT with an empty FIFO; feeds two bytes and watches them come out as init bytes.
  task automatic run_init(input int b0, input int b1);
    drive_src(1, b0);
    #1 check_output("init_empty_valid", init_valid, 0);
    tick();
    drive_src(1, b1);
    #1 check_output("init0_valid", init_valid, 1);
    check_output("init0_data", init_data, b0);
    tick();
    drive_src(0, 0);
    #1 check_output("init1_valid", init_valid, 1);
    check_output("init1_data", init_data, b1);
    check_output("init1_busy", busy, 1);
    tick();
    check_output("init_done_busy", busy, 0);
    check_output("init_done_bn", bits_needed, -8);
  endtask

  task automatic apply_stimulus_random(input int cycles);
    int step, sum, e_byte, e_shift, e_lane;
    bit ov, byp, ren, sv, need, e_rdy, acc, inj, e_src_rdy;
    int nb, nbits, sd;
    for (int c = 0; c < cycles; c++) begin
      ov    = ($urandom_range(0, 3) != 0);
      byp   = $urandom_range(0, 1);
      nb    = $urandom_range(0, 3);
      ren   = $urandom_range(0, 1);
      nbits = $urandom_range(0, 6);
      sv    = $urandom_range(0, 1);
      sd    = $urandom_range(0, 255);
      drive_op(ov, byp, nb, ren, nbits);
      drive_src(sv, sd);

      step      = byp ? nb + 1 : (ren ? nbits : 0);
      sum       = m_bn + step;
      need      = (sum >= 0);
      e_rdy     = !(need && m_q.size() == 0);
      acc       = ov && e_rdy;
      inj       = acc && need;
      e_byte    = inj ? int'(m_q[0]) : 0;
      e_shift   = (inj && !byp) ? sum : 0;
      e_lane    = (inj && byp) ? -m_bn - 1 : 0;
      e_src_rdy = (m_q.size() < 4);

      #1;
      check_output("rnd_op_ready", bus.op_ready, int'(e_rdy));
      check_output("rnd_inject_en", bus.inject_en, int'(inj));
      check_output("rnd_inject_byte", bus.inject_byte, e_byte);
      check_output("rnd_inject_shift", bus.inject_shift, e_shift);
      check_output("rnd_inject_lane", bus.inject_lane, e_lane);
      check_output("rnd_src_ready", bus.src_ready, int'(e_src_rdy));

      if (acc) m_bn = need ? sum - 8 : sum;
      if (inj) void'(m_q.pop_front());
      if (sv && e_src_rdy) m_q.push_back(8'(sd));

      tick();
      check_output("rnd_bits_needed", bits_needed, m_bn);
    end
    drive_op(0, 0, 0, 0, 0);
    drive_src(0, 0);
  endtask

  initial begin
    vecs[0]  = '{0, 0, 0, 0, 0, 1, 'h11, 1, 0, 0,    0, 0, -8};
    vecs[1]  = '{1, 0, 0, 1, 6, 1, 'h22, 1, 0, 0,    0, 0, -2};
    vecs[2]  = '{1, 0, 0, 1, 3, 1, 'h33, 1, 1, 'h11, 1, 0, -7};
    vecs[3]  = '{1, 1, 3, 0, 0, 0, 0,    1, 0, 0,    0, 0, -3};
    vecs[4]  = '{1, 1, 3, 0, 0, 0, 0,    1, 1, 'h22, 0, 2, -7};
    vecs[5]  = '{1, 1, 3, 0, 0, 0, 0,    1, 0, 0,    0, 0, -3};
    vecs[6]  = '{1, 1, 0, 0, 0, 0, 0,    1, 0, 0,    0, 0, -2};
    vecs[7]  = '{1, 1, 1, 0, 0, 0, 0,    1, 1, 'h33, 0, 1, -8};
    vecs[8]  = '{1, 1, 3, 0, 0, 0, 0,    1, 0, 0,    0, 0, -4};
    vecs[9]  = '{1, 1, 3, 0, 0, 1, 'h44, 0, 0, 0,    0, 0, -4};
    vecs[10] = '{1, 1, 3, 0, 0, 0, 0,    1, 1, 'h44, 0, 3, -8};
    vecs[11] = '{1, 0, 0, 0, 5, 0, 0,    1, 0, 0,    0, 0, -8};

    reset = 1'b1;
    start = 1'b0;
    start3 = 1'b0;
    drive_op(0, 0, 0, 0, 0);
    drive_src(0, 0);
    bus3.op_valid = 1'b0; bus3.bypass = 1'b0; bus3.n_bin = 2'd0;
    bus3.renorm = 1'b0; bus3.num_bits = 3'd0; bus3.src_valid = 1'b0; bus3.src_data = 8'd0;

    #12;
    check_output("rst_bits_needed", bits_needed, -8);
    check_output("rst_busy", busy, 1);
    check_output("rst_err", err, 0);
    check_output("rst_src_ready", bus.src_ready, 0);
    check_output("rst_op_ready", bus.op_ready, 0);
    check_output("rst_inject_en", bus.inject_en, 0);
    check_output("rst_init_valid", init_valid, 0);
    reset = 1'b0;
    tick();

    drive_op(1, 0, 0, 0, 0);
    #1 check_output("idle_op_ready", bus.op_ready, 0);
    tick();
    check_output("idle_op_err", err, 1);
    drive_op(0, 0, 0, 0, 0);
    pulse_start();
    check_output("start_clears_err", err, 0);
    check_output("start_busy", busy, 1);

    run_init('hA5, 'h3C);

    for (int i = 0; i < 12; i++) begin
      drive_op(vecs[i].ov, vecs[i].byp, vecs[i].nb, vecs[i].ren, vecs[i].nbits);
      drive_src(vecs[i].sv, vecs[i].sd);
      #1;
      check_output($sformatf("vec%0d_op_ready", i), bus.op_ready, int'(vecs[i].e_rdy));
      check_output($sformatf("vec%0d_inject_en", i), bus.inject_en, int'(vecs[i].e_inj));
      check_output($sformatf("vec%0d_inject_byte", i), bus.inject_byte, vecs[i].e_byte);
      check_output($sformatf("vec%0d_inject_shift", i), bus.inject_shift, vecs[i].e_shift);
      check_output($sformatf("vec%0d_inject_lane", i), bus.inject_lane, vecs[i].e_lane);
      tick();
      check_output($sformatf("vec%0d_bits_needed", i), bits_needed, vecs[i].e_bn);
    end

    // Fill the FIFO, then consume while the source keeps offering a fifth byte.
    drive_op(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive_src(1, 'hB0 + i);
      #1 check_output($sformatf("fill%0d_src_ready", i), bus.src_ready, 1);
      tick();
    end
    drive_src(1, 'hC0);
    drive_op(1, 1, 3, 0, 0);
    #1 check_output("full_src_ready", bus.src_ready, 0);
    check_output("full_op_ready", bus.op_ready, 1);
    tick();
    check_output("full_bn_a", bits_needed, -4);
    #1 check_output("full_pop_src_ready", bus.src_ready, 0);
    check_output("full_pop_inject_en", bus.inject_en, 1);
    check_output("full_pop_inject_byte", bus.inject_byte, 'hB0);
    tick();
    check_output("full_bn_b", bits_needed, -8);
    drive_op(0, 0, 0, 0, 0);
    #1 check_output("after_pop_src_ready", bus.src_ready, 1);
    tick();
    drive_src(0, 0);
    #1 check_output("refull_src_ready", bus.src_ready, 0);
    drive_op(1, 1, 3, 0, 0);
    tick();
    #1 check_output("drain_inject_byte", bus.inject_byte, 'hB1);
    tick();
    tick();
    check_output("pre_start_bn", bits_needed, -4);

    // Three bytes queued and an op that would inject: start must win.
    start = 1'b1;
    drive_src(1, 'hD0);
    #1 check_output("start_cycle_inject_en", bus.inject_en, 0);
    tick();
    start = 1'b0;
    drive_op(0, 0, 0, 0, 0);
    drive_src(0, 0);
    #1 check_output("restart_busy", busy, 1);
    check_output("restart_bn", bits_needed, -8);
    check_output("restart_fifo_empty", init_valid, 0);
    check_output("restart_src_ready", bus.src_ready, 1);

    run_init('hE1, 'hE2);
    m_q.delete();
    m_bn = -8;
    apply_stimulus_random(400);

    drive_op(1, 0, 0, 1, 7);
    #1 check_output("bad_nbits_op_ready", bus.op_ready, 0);
    check_output("bad_nbits_inject_en", bus.inject_en, 0);
    tick();
    check_output("bad_nbits_err", err, 1);
    check_output("bad_nbits_bn_hold", bits_needed, m_bn);
    drive_op(0, 0, 0, 0, 0);
    pulse_start();
    check_output("bad_nbits_err_cleared", err, 0);

    start3 = 1'b1;
    #1;
    tick();
    start3 = 1'b0;
    bus3.src_valid = 1'b1; bus3.src_data = 8'h01;
    tick();
    bus3.src_data = 8'h02;
    tick();
    bus3.src_valid = 1'b0;
    tick();
    check_output("bw3_busy", busy3, 0);
    check_output("bw3_err_before", err3, 0);
    bus3.op_valid = 1'b1; bus3.bypass = 1'b1; bus3.n_bin = 2'd3;
    #1 check_output("bw3_op_ready", bus3.op_ready, 0);
    check_output("bw3_inject_en", bus3.inject_en, 0);
    tick();
    check_output("bw3_err", err3, 1);
    check_output("bw3_bn_hold", bits_needed3, -8);
    bus3.op_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
